// File: rtl/gpif_pkg.sv
// rtl/gpif_pkg.sv - shared types and constants for the GPIF-II slave-FIFO sequencer
package gpif_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4
  } gpif_state_t;

  localparam int NUM_CH = 4;

  // Channel indices, one per FX3 socket
  localparam logic [1:0] CH_RX  = 2'd0;  // RX samples to host (write)
  localparam logic [1:0] CH_TX  = 2'd1;  // TX samples from host (read)
  localparam logic [1:0] CH_CMD = 2'd2;  // command read
  localparam logic [1:0] CH_RSP = 2'd3;  // response write

  // Bit n set = channel n drives fdata toward the FX3
  localparam logic [3:0] CH_IS_WRITE = 4'b1001;

  // Socket address per channel, packed {ch3, ch2, ch1, ch0}
  localparam logic [7:0] SOCK_ADDR_MAP = {2'd3, 2'd2, 2'd1, 2'd0};

  function automatic logic [1:0] sock_addr(input logic [1:0] ch);
    return SOCK_ADDR_MAP[{ch, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/gpif_rr_arbiter.sv
// rtl/gpif_rr_arbiter.sv - 4-way round-robin pick starting after the last winner
module gpif_rr_arbiter
  import gpif_pkg::*;
(
  input  logic [1:0] ptr,
  input  logic [3:0] eligible,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       valid
);

  logic [1:0] cand;

  // Scan ptr+1, ptr+2, ptr+3, ptr; the first eligible channel wins
  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    valid     = 1'b0;
    cand      = ptr;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = ptr + 2'(i);
      if (!valid && eligible[cand]) begin
        valid     = 1'b1;
        grant_idx = cand;
      end
    end
    grant[grant_idx] = valid;
  end

endmodule

// File: rtl/gpif_fifo_arbiter.sv
// rtl/gpif_fifo_arbiter.sv - slave-FIFO bus sequencer sharing the GPIF between four channels
module gpif_fifo_arbiter
  import gpif_pkg::*;
#(
  parameter int BURST_LEN  = 256,
  parameter int RD_LATENCY = 2,
  parameter int TURNAROUND = 1
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic [3:0] req,
  input  logic       rsp_last,
  input  logic [3:0] flag_b,
  output logic [1:0] faddr,
  output logic       slcs_b,
  output logic       slwr_b,
  output logic       slrd_b,
  output logic       sloe_b,
  output logic       pktend_b,
  output logic [3:0] grant,
  output logic       fdata_oe,
  output logic       src_pop,
  output logic       rd_valid,
  output logic       busy
);

  localparam int BW   = $clog2(BURST_LEN + 1);
  localparam int WMAX = (TURNAROUND > RD_LATENCY) ? TURNAROUND : RD_LATENCY;
  localparam int WW   = $clog2(WMAX + 1);

  localparam logic [BW-1:0] BURST_MAX  = BW'(BURST_LEN);
  localparam logic [BW-1:0] BURST_PRE  = BW'(BURST_LEN - 1);
  localparam logic [WW-1:0] TURN_LAST  = WW'(TURNAROUND - 1);
  localparam logic [WW-1:0] DRAIN_LAST = WW'(RD_LATENCY - 1);

  gpif_state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [1:0]    ptr_q;
  logic [1:0]    ch_q;
  logic [1:0]    faddr_q;
  logic [3:0]    grant_q;
  logic [RD_LATENCY-1:0] rd_pipe_q;

  logic [3:0] arb_grant;
  logic [1:0] arb_idx;
  logic       arb_valid;
  logic       arb_take;
  logic       ch_write;
  logic       ch_ready;

  gpif_rr_arbiter u_rr (
    .ptr       (ptr_q),
    .eligible  (req & flag_b),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  assign ch_write = CH_IS_WRITE[ch_q];
  assign ch_ready = req[ch_q] && flag_b[ch_q];

  // Next state and bus strobes; strobes follow req/flag in the same cycle
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    wcnt_d   = wcnt_q;
    arb_take = 1'b0;
    slcs_b   = 1'b1;
    slwr_b   = 1'b1;
    slrd_b   = 1'b1;
    sloe_b   = 1'b1;
    pktend_b = 1'b1;
    fdata_oe = 1'b0;
    src_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          arb_take = 1'b1;
          wcnt_d   = '0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        slcs_b   = 1'b0;
        sloe_b   = ch_write;
        fdata_oe = ch_write;
        if (wcnt_q == TURN_LAST) begin
          beat_d  = '0;
          state_d = ch_write ? ST_WRITE : ST_READ;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      ST_WRITE: begin
        slcs_b   = 1'b0;
        fdata_oe = 1'b1;
        if (ch_ready) begin
          slwr_b  = 1'b0;
          src_pop = 1'b1;
          beat_d  = beat_q + BW'(1);
          if (ch_q == CH_RSP && rsp_last) begin
            pktend_b = 1'b0;
            state_d  = ST_IDLE;
          end else if (beat_q == BURST_PRE) begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        slcs_b = 1'b0;
        sloe_b = 1'b0;
        if (ch_ready && beat_q != BURST_MAX) begin
          slrd_b = 1'b0;
          beat_d = beat_q + BW'(1);
        end else begin
          wcnt_d  = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        slcs_b = 1'b0;
        sloe_b = 1'b0;
        if (wcnt_q == DRAIN_LAST) begin
          state_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, beat and wait counters
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Latch the winner at arbitration; drop the grant as the burst returns to IDLE
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ptr_q   <= 2'd3;
      ch_q    <= '0;
      faddr_q <= '0;
      grant_q <= '0;
    end else if (arb_take) begin
      ptr_q   <= arb_idx;
      ch_q    <= arb_idx;
      faddr_q <= sock_addr(arb_idx);
      grant_q <= arb_grant;
    end else if (state_d == ST_IDLE) begin
      grant_q <= '0;
    end
  end

  generate
    if (RD_LATENCY == 1) begin : g_rd_lat1
      // Read strobe delayed one cycle marks the word on fdata
      always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) rd_pipe_q <= '0;
        else          rd_pipe_q <= ~slrd_b;
      end
    end else begin : g_rd_latn
      // Read strobe delayed RD_LATENCY cycles marks the word on fdata
      always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) rd_pipe_q <= '0;
        else          rd_pipe_q <= {rd_pipe_q[RD_LATENCY-2:0], ~slrd_b};
      end
    end
  endgenerate

  assign rd_valid = rd_pipe_q[RD_LATENCY-1];
  assign faddr    = faddr_q;
  assign grant    = grant_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpif_fifo_arbiter.sv
// tb/tb_gpif_fifo_arbiter.sv - directed and randomized checks of gpif_fifo_arbiter
module tb_gpif_fifo_arbiter;

  logic       clk = 1'b0;
  logic       reset_b = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] flag_b = '0;
  logic       rsp_last = 1'b0;

  logic [1:0] faddr;
  logic       slcs_b, slwr_b, slrd_b, sloe_b, pktend_b;
  logic [3:0] grant;
  logic       fdata_oe, src_pop, rd_valid, busy;

  logic [1:0] faddr_4;
  logic       slcs_b_4, slwr_b_4, slrd_b_4, sloe_b_4, pktend_b_4;
  logic [3:0] grant_4;
  logic       fdata_oe_4, src_pop_4, rd_valid_4, busy_4;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_n, rd_n, pop_n, pk_n, rv_n, wr4_n;

  always #5 clk = ~clk;

  gpif_fifo_arbiter dut (
    .clk(clk), .reset_b(reset_b), .req(req), .rsp_last(rsp_last), .flag_b(flag_b),
    .faddr(faddr), .slcs_b(slcs_b), .slwr_b(slwr_b), .slrd_b(slrd_b), .sloe_b(sloe_b),
    .pktend_b(pktend_b), .grant(grant), .fdata_oe(fdata_oe), .src_pop(src_pop),
    .rd_valid(rd_valid), .busy(busy)
  );

  gpif_fifo_arbiter #(.BURST_LEN(4)) dut4 (
    .clk(clk), .reset_b(reset_b), .req(req), .rsp_last(rsp_last), .flag_b(flag_b),
    .faddr(faddr_4), .slcs_b(slcs_b_4), .slwr_b(slwr_b_4), .slrd_b(slrd_b_4), .sloe_b(sloe_b_4),
    .pktend_b(pktend_b_4), .grant(grant_4), .fdata_oe(fdata_oe_4), .src_pop(src_pop_4),
    .rd_valid(rd_valid_4), .busy(busy_4)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wr_n = 0; rd_n = 0; pop_n = 0; pk_n = 0; rv_n = 0; wr4_n = 0;
  endtask

  // Drive inputs on the falling edge, then sample what the next rising edge will see
  task automatic tick(input logic [3:0] r, input logic [3:0] f, input logic last);
    @(negedge clk);
    req = r; flag_b = f; rsp_last = last;
    #1;
    cyc++;
    if (!slwr_b)   wr_n++;
    if (!slrd_b)   rd_n++;
    if (src_pop)   pop_n++;
    if (!pktend_b) pk_n++;
    if (rd_valid)  rv_n++;
    if (!slwr_b_4) wr4_n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_b = 1'b0; req = '0; flag_b = '0; rsp_last = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && busy; i++) tick(4'b0000, 4'b1111, 1'b0);
    chk(tag, int'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int setup_n, addr_bad, ng, direct, lag_bad, last_s, pk_at;
  logic [3:0] prev_g, r, f;
  logic       l;
  int order[5];
  int exp_order[5] = '{1, 2, 4, 8, 1};
  int slrd_at[$];
  int rv_at[$];
  logic sloe_hist[64];
  int ch, k, last_at, exp_n, n;
  logic is_wr, ends_pk;

  initial begin
    // reset values, applied asynchronously before any clock edge
    #2 reset_b = 1'b0;
    #1;
    chk("rst_strobes", int'({slcs_b, slwr_b, slrd_b, sloe_b, pktend_b}), 31);
    chk("rst_faddr", int'(faddr), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_misc", int'({fdata_oe, src_pop, rd_valid, busy}), 0);
    @(negedge clk);
    reset_b = 1'b1;

    // ch0 full burst of 256
    clr(); setup_n = 0; addr_bad = 0;
    for (int i = 0; i < 400 && wr_n < 256; i++) begin
      tick(4'b0001, 4'b1111, 1'b0);
      if (busy && slwr_b && wr_n == 0) setup_n++;
      if (!slwr_b && faddr != 2'd0) addr_bad++;
    end
    chk("t1_setup_cycles", setup_n, 1);
    chk("t1_writes", wr_n, 256);
    chk("t1_pops", pop_n, 256);
    chk("t1_pktend", pk_n, 0);
    chk("t1_faddr", addr_bad, 0);
    tick(4'b0000, 4'b1111, 1'b0);
    chk("t1_idle_busy", int'(busy), 0);
    chk("t1_idle_grant", int'(grant), 0);
    chk("t1_idle_oe", int'({fdata_oe, slwr_b, slcs_b}), 3);

    // round-robin order with all channels requesting
    do_reset(); clr(); ng = 0; direct = 0; prev_g = '0;
    for (int i = 0; i < 2000 && ng < 5; i++) begin
      tick(4'b1111, 4'b1111, 1'b0);
      if (grant != 0 && prev_g == 0) begin
        order[ng] = int'(grant);
        ng++;
      end
      if (grant != 0 && prev_g != 0 && grant != prev_g) direct++;
      prev_g = grant;
    end
    chk("t2_grants_seen", ng, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), order[i], exp_order[i]);
    chk("t2_no_idle_gap", direct, 0);
    wait_idle("t2_idle");

    // ch1 read, flag drops after 10 strobes
    do_reset(); clr(); slrd_at.delete(); rv_at.delete();
    for (int c = 0; c < 40; c++) begin
      tick(4'b0010, (rd_n < 10) ? 4'b1111 : 4'b1101, 1'b0);
      if (!slrd_b) slrd_at.push_back(c);
      if (rd_valid) rv_at.push_back(c);
      sloe_hist[c] = sloe_b;
    end
    chk("t3_rd_strobes", rd_n, 10);
    chk("t3_rd_valid", rv_n, 10);
    lag_bad = 0;
    for (int i = 0; i < slrd_at.size() && i < rv_at.size(); i++)
      if (rv_at[i] != slrd_at[i] + 2) lag_bad++;
    chk("t3_rd_lag", lag_bad, 0);
    last_s = (slrd_at.size() > 0) ? slrd_at[slrd_at.size()-1] : 0;
    chk("t3_sloe_plus1", int'(sloe_hist[last_s+1]), 0);
    chk("t3_sloe_plus2", int'(sloe_hist[last_s+2]), 0);
    chk("t3_sloe_end", int'(sloe_hist[39]), 1);

    // ch3 response ending on the 5th word
    do_reset(); clr(); pk_at = -1;
    for (int c = 0; c < 30; c++) begin
      tick((wr_n >= 5) ? 4'b0000 : 4'b1000, 4'b1111, wr_n == 4);
      if (!pktend_b) pk_at = wr_n;
    end
    chk("t4_writes", wr_n, 5);
    chk("t4_pktend_n", pk_n, 1);
    chk("t4_pktend_word", pk_at, 5);
    chk("t4_idle", int'(busy), 0);

    // asynchronous reset during beat 100
    do_reset(); clr();
    for (int i = 0; i < 200 && wr_n < 100; i++) tick(4'b0001, 4'b1111, 1'b0);
    chk("t5_beat100", wr_n, 100);
    chk("t5_strobing", int'(slwr_b), 0);
    #1 reset_b = 1'b0;
    #1;
    chk("t5_async_strobes", int'({slcs_b, slwr_b, slrd_b, sloe_b, pktend_b}), 31);
    chk("t5_async_regs", int'({grant, fdata_oe, src_pop, busy}), 0);
    @(negedge clk);
    reset_b = 1'b1;
    for (int i = 0; i < 10 && grant == 0; i++) tick(4'b1111, 4'b1111, 1'b0);
    chk("t5_first_after_reset", int'(grant), 1);
    wait_idle("t5_idle");

    // BURST_LEN=4 instance, flag drops right as the burst completes
    do_reset(); clr();
    for (int c = 0; c < 20; c++) tick(4'b0001, (wr4_n < 4) ? 4'b1111 : 4'b1110, 1'b0);
    chk("t6_writes", wr4_n, 4);
    chk("t6_idle", int'({busy_4, grant_4, fdata_oe_4}), 0);

    // randomized single-channel transactions against a count model
    do_reset();
    for (int t = 0; t < 12; t++) begin
      ch      = $urandom_range(0, 3);
      k       = $urandom_range(1, 20);
      last_at = $urandom_range(1, 25);
      is_wr   = (ch == 0 || ch == 3);
      ends_pk = (ch == 3 && last_at <= k);
      exp_n   = ends_pk ? last_at : k;
      clr(); addr_bad = 0;
      for (int c = 0; c < 60; c++) begin
        n = wr_n + rd_n;
        r = (n < k && pk_n == 0) ? (4'b0001 << ch) : 4'b0000;
        f = 4'($urandom);
        f[ch] = (n < k);
        l = (ch == 3) ? (n == last_at - 1) : 1'($urandom);
        tick(r, f, l);
        if ((!slwr_b || !slrd_b) && int'(faddr) != ch) addr_bad++;
      end
      chk($sformatf("rnd%0d_ch%0d_wr", t, ch), wr_n, is_wr ? exp_n : 0);
      chk($sformatf("rnd%0d_ch%0d_pop", t, ch), pop_n, is_wr ? exp_n : 0);
      chk($sformatf("rnd%0d_ch%0d_rd", t, ch), rd_n, is_wr ? 0 : exp_n);
      chk($sformatf("rnd%0d_ch%0d_rv", t, ch), rv_n, is_wr ? 0 : exp_n);
      chk($sformatf("rnd%0d_ch%0d_pk", t, ch), pk_n, ends_pk ? 1 : 0);
      chk($sformatf("rnd%0d_ch%0d_addr", t, ch), addr_bad, 0);
      chk($sformatf("rnd%0d_ch%0d_idle", t, ch), int'(busy), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpif_fifo_arbiter.md
Name: gpif_fifo_arbiter

Overview:
Sequences the FX3 GPIF-II slave-FIFO bus and shares it between four on-chip channels, one per FX3 socket address:
- ch0: RX sample write to host.
- ch1: TX sample read from host.
- ch2: command read.
- ch3: response write.

It sits beside gpif_wrapper and owns faddr and all slave-FIFO strobes. The fdata mux and capture registers stay in the datapath, driven by this block's grant and strobe outputs. Channels are served in bounded bursts under round-robin arbitration.

Parameters:
BURST_LEN, 256, maximum words per grant (>=2, <=1024)
RD_LATENCY, 2, cycles from slrd_b low to valid fdata on the bus
TURNAROUND, 1, cycles faddr/sloe_b are settled before the first strobe (>=1)

Ports:
clk  in  1  system/GPIF clock
reset_b  in  1  asynchronous active-low reset
req  in  4  per-channel request; write ch: source holds >=1 word; read ch: sink has space
rsp_last  in  1  ch3 word currently presented is the final word of the response
flag_b  in  4  {flagd_b,flagc_b,flagb_b,flaga_b}; bit n high = socket n ready (not full for write, not empty for read)
faddr  out  2  socket address
slcs_b  out  1  chip select, active low
slwr_b  out  1  write strobe, active low
slrd_b  out  1  read strobe, active low
sloe_b  out  1  output enable, active low
pktend_b  out  1  short-packet end, active low
grant  out  4  one-hot granted channel; 0 when idle
fdata_oe  out  1  FPGA drives fdata (write channel granted, SETUP through WRITE)
src_pop  out  1  write word consumed this cycle (FWFT source of granted channel)
rd_valid  out  1  fdata holds a valid read word for the granted channel this cycle
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, immediate):
  - slcs_b, slwr_b, slrd_b, sloe_b and pktend_b high.
  - faddr=0, grant=0, fdata_oe=0, src_pop=0, rd_valid=0, busy=0.
  - State IDLE; round-robin pointer = 3, so ch0 has first priority.
  - Reset mid-burst aborts with no pktend.
- Directions are fixed: ch0 and ch3 write, ch1 and ch2 read.
- IDLE: channel n is eligible when req[n] && flag_b[n]. Pick the first eligible channel after the pointer (round-robin), register grant/faddr, set pointer = winner, go to SETUP. No eligible channel: stay in IDLE.
- SETUP: slcs_b=0; sloe_b=0 for read channels; fdata_oe=1 for write channels. Wait TURNAROUND cycles, clear the beat counter, then go to WRITE or READ.
- WRITE: each cycle with req[ch] && flag_b[ch]:
  - slwr_b=0, src_pop=1, beat++ (same cycle).
  - On ch3, if rsp_last is set on a popped word, pktend_b=0 on that same cycle, then go to IDLE.
  - Burst ends after BURST_LEN beats, or on the first cycle where req or flag is low (no strobe that cycle). Then go to IDLE.
  - A ch3 burst that hits BURST_LEN without rsp_last ends with no pktend. The response continues in a later grant.
- READ: slrd_b=0 each cycle while req[ch] && flag_b[ch] && beat<BURST_LEN, beat++. On the first failing cycle, deassert slrd_b and go to DRAIN.
- DRAIN: hold sloe_b=0 and slcs_b=0 for RD_LATENCY cycles, then go to IDLE.
- rd_valid = slrd_b-low delayed exactly RD_LATENCY cycles. In-flight words are always delivered, even when the flag drops.
- Leaving a burst: all strobes high, grant=0, fdata_oe=0 on the IDLE cycle. There is one idle bus cycle minimum between bursts.
- Simultaneous events: flag_b drop and BURST_LEN reached on the same cycle → normal end, no extra strobe. Request changes during SETUP are ignored until WRITE/READ.
- The beat counter is clog2(BURST_LEN+1) bits and never wraps. The RR pointer wraps 3→0.

Decomposition:
- gpif_pkg: state enum (IDLE, SETUP, WRITE, READ, DRAIN), channel indices, CH_IS_WRITE 4-bit mask, socket address constants.
- Sub-module gpif_rr_arbiter: 4-way round-robin with pointer input, eligible vector, one-hot grant and valid outputs.

Test Plan:
- Reset release, req=0001, flags 1111 → SETUP 1 cycle, then 256 cycles slwr_b=0 with faddr=0, src_pop count 256, then IDLE; pktend_b never low.
- req=1111 held, flags ready → grants in order ch0, ch1, ch2, ch3, ch0; at least one idle cycle between bursts.
- ch1 read, flag_b[1] drops after 10 strobes → exactly 10 slrd_b pulses, rd_valid 10 pulses lagging by 2, sloe_b low 2 cycles past the last strobe.
- ch3 write, rsp_last on the 5th word → 5 slwr_b pulses, pktend_b low only on the 5th, then IDLE.
- reset_b low during beat 100 of a ch0 burst → all strobes high asynchronously. After release, ch0 is served first again.
- BURST_LEN=4, flag_b[0] drop coinciding with beat 4 → 4 writes, no 5th strobe, clean return to IDLE.
